beep_seq: RTL and testbench



---
 rtl/beep_pkg.sv | 20 ++
 rtl/beep_ms_tick.sv | 32 +++
 rtl/beep_seq.sv | 158 +++++++++++++++
 tb/tb_beep_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep sequencer: FSM state encoding,
// ms prescaler divisor and the on-time clamp.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

    // A zero on-time would never let ON finish, so it is stretched to 1 ms.
    function automatic int unsigned on_clamp(input int unsigned ms);
        return (ms == 0) ? 1 : ms;
    endfunction

endpackage

// File: rtl/beep_ms_tick.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1 and flags the terminal
// value; a synchronous clear restarts the count so durations align to it.
module beep_ms_tick
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ = 48000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV = ms_div(CLK_HZ);
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/beep_seq.sv
// Cadenced square-wave beeper: N beeps (or continuous) with programmable tone,
// on and off times. Define BEEP_WARBLE_EN to drop odd-index beeps one octave.
module beep_seq
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ = 48000000,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned MS_W   = 12,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] half_period,
    input  logic [MS_W-1:0]  on_ms,
    input  logic [MS_W-1:0]  off_ms,
    input  logic [CNT_W-1:0] count,
    output logic             beep,
    output logic             busy,
    output logic             done
);

`ifdef BEEP_WARBLE_EN
    localparam int unsigned TW = DIV_W + 1;
`else
    localparam int unsigned TW = DIV_W;
`endif

    localparam logic [TW-1:0]    TONE_ONE = TW'(1);
    localparam logic [MS_W-1:0]  MS_ONE   = MS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state, state_nx;

    logic [DIV_W-1:0] hp_l;
    logic [MS_W-1:0]  on_l, off_l, on_lim, ms_cnt;
    logic [CNT_W-1:0] cnt_l, beep_cnt, beep_cnt_nx;
    logic [TW-1:0]    tone_cnt, hp_eff;
    logic             load, enter, on_end, fin, ms_clr, tick, tone_wrap;

    beep_ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ms_clr),
        .tick  (tick)
    );

`ifdef BEEP_WARBLE_EN
    assign hp_eff = beep_cnt[0] ? {hp_l, 1'b0} : {1'b0, hp_l};
`else
    assign hp_eff = hp_l;
`endif

    assign on_lim      = MS_W'(on_clamp(32'(on_l)));
    assign beep_cnt_nx = beep_cnt + CNT_ONE;
    assign tone_wrap   = (hp_eff != '0) && (tone_cnt == hp_eff - TONE_ONE);
    assign ms_clr      = load | enter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // stop outranks everything, including a start or a completing beep.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        enter    = 1'b0;
        on_end   = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    load     = 1'b1;
                    state_nx = ON;
                end
            end
            ON: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (tick && ms_cnt == on_lim - MS_ONE) begin
                    on_end = 1'b1;
                    if (cnt_l != '0 && beep_cnt_nx == cnt_l) begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        enter    = 1'b1;
                        state_nx = (off_l == '0) ? ON : OFF;
                    end
                end
            end
            OFF: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (tick && ms_cnt == off_l - MS_ONE) begin
                    enter    = 1'b1;
                    state_nx = ON;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_l     <= '0;
            on_l     <= '0;
            off_l    <= '0;
            cnt_l    <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
            beep_cnt <= '0;
            beep     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= fin;

            if (load) begin
                hp_l  <= half_period;
                on_l  <= on_ms;
                off_l <= off_ms;
                cnt_l <= count;
            end

            if (load || enter) begin
                ms_cnt <= '0;
            end else if (state != IDLE && tick) begin
                ms_cnt <= ms_cnt + MS_ONE;
            end

            if (load || enter) begin
                tone_cnt <= '0;
            end else if (state == ON && hp_eff != '0) begin
                tone_cnt <= tone_wrap ? '0 : tone_cnt + TONE_ONE;
            end

            if (load) begin
                beep_cnt <= '0;
            end else if (on_end) begin
                beep_cnt <= beep_cnt_nx;
            end

            // Tone only runs while staying in ON; any exit or re-entry silences it.
            if (state != ON || state_nx != ON || enter) begin
                beep <= 1'b0;
            end else if (tone_wrap) begin
                beep <= ~beep;
            end
        end
    end

endmodule

// File: tb/tb_beep_seq.sv
// Scoreboard bench for beep_seq: a cycle-level model of each run queues the
// expected output changes; a monitor matches every observed change against it.
module tb_beep_seq;

    localparam int CLK_HZ = 10000;
    localparam int MS     = 10;
    localparam int DIV_W  = 16;
    localparam int MS_W   = 12;
    localparam int CNT_W  = 4;
`ifdef BEEP_WARBLE_EN
    localparam bit WARBLE = 1'b1;
`else
    localparam bit WARBLE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] half_period = '0;
    logic [MS_W-1:0]  on_ms = '0;
    logic [MS_W-1:0]  off_ms = '0;
    logic [CNT_W-1:0] count = '0;
    logic             beep, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit skip = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } ev_t;

    ev_t        q[$];
    logic [2:0] mprev = 3'b000;
    logic [2:0] prev_s = 3'b000;

    beep_seq #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W),
        .MS_W   (MS_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .on_ms       (on_ms),
        .off_ms      (off_ms),
        .count       (count),
        .beep        (beep),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are packed as {beep, busy, done}; only changes are compared.
    always @(negedge clk) begin
        logic [2:0] v;
        ev_t        e;
        v = {beep, busy, done};
        if (!skip && v !== prev_s) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, v);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.v !== v) begin
                    errors++;
                    $display("FAIL output_event got cyc=%0d val=%b expected cyc=%0d val=%b",
                             cyc, v, e.cyc, e.v);
                end
            end
        end
        prev_s = v;
    end

    task automatic push_v(input int t0, input int r, input logic [2:0] v);
        ev_t e;
        if (v !== mprev) begin
            e.cyc = t0 + r;
            e.v   = v;
            q.push_back(e);
        end
        mprev = v;
    endtask

    // Expected outputs per cycle r after the accepting edge (r=0), from the
    // cadence rules: beeps of lon cycles toggling every hp, gaps of loff cycles.
    task automatic build(input int hp, input int on, input int off, input int cnt,
                         input int s, input int t0, output int last_r);
        int   lon, loff, base, i, hpi, r;
        bit   last, stopped, quit;
        logic b, f;
        lon     = ((on == 0) ? 1 : on) * MS;
        loff    = off * MS;
        base    = 0;
        i       = 0;
        stopped = 1'b0;
        quit    = 1'b0;
        last_r  = 0;
        mprev   = 3'b000;
        push_v(t0, 0, 3'b010);
        while (!quit) begin
            hpi  = (WARBLE && (i % 2 == 1)) ? 2 * hp : hp;
            last = (cnt != 0) && (i == cnt - 1);
            for (int j = 1; j <= lon && !stopped; j++) begin
                r = base + j;
                if (s != 0 && r >= s) begin
                    stopped = 1'b1;
                end else begin
                    b = (j < lon && hpi != 0) ? (((j / hpi) % 2) == 1) : 1'b0;
                    f = last && (j == lon);
                    push_v(t0, r, {b, ~f, f});
                end
            end
            if (stopped) begin
                quit = 1'b1;
            end else if (last) begin
                push_v(t0, base + lon + 1, 3'b000);
                last_r = base + lon + 1;
                quit   = 1'b1;
            end else begin
                for (int j = 1; j <= loff && !stopped; j++) begin
                    r = base + lon + j;
                    if (s != 0 && r >= s) stopped = 1'b1;
                    else push_v(t0, r, 3'b010);
                end
                if (stopped) quit = 1'b1;
                base += lon + loff;
                i++;
            end
        end
        if (stopped) begin
            push_v(t0, s, 3'b000);
            last_r = s;
        end
    endtask

    task automatic run(input int hp, input int on, input int off, input int cnt,
                       input int s, input bit noise);
        int t0, last_r;
        @(negedge clk);
        half_period = DIV_W'(hp);
        on_ms       = MS_W'(on);
        off_ms      = MS_W'(off);
        count       = CNT_W'(cnt);
        start       = 1'b1;
        stop        = 1'b0;
        t0          = cyc + 1;
        build(hp, on, off, cnt, s, t0, last_r);
        for (int r = 0; r <= last_r; r++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (s != 0 && r + 1 == s);
            if (noise && r + 1 < last_r) begin
                start       = 1'($urandom_range(0, 1));
                half_period = DIV_W'($urandom);
                on_ms       = MS_W'($urandom);
                off_ms      = MS_W'($urandom);
                count       = CNT_W'($urandom);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d outstanding expected 0 (hp=%0d on=%0d off=%0d cnt=%0d)",
                     q.size(), hp, on, off, cnt);
            q.delete();
        end
    endtask

    task automatic run_reset();
        int t0, last_r;
        @(negedge clk);
        half_period = DIV_W'(3);
        on_ms       = MS_W'(2);
        off_ms      = MS_W'(1);
        count       = CNT_W'(1);
        start       = 1'b1;
        t0          = cyc + 1;
        build(3, 2, 1, 1, 0, t0, last_r);
        for (int r = 0; r <= 4; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        skip  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({beep, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset got beep/busy/done=%b expected 000", {beep, busy, done});
        end
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 skip = 1'b0;
    endtask

    initial begin
        int hp, on, off, cnt, s, end_edge, lon;
        bit noise;

        #1;
        checks++;
        if ({beep, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state got beep/busy/done=%b expected 000", {beep, busy, done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(3, 2, 1, 1, 0, 1'b0);     // single beep
        run(3, 1, 2, 3, 0, 1'b0);     // three beeps, 70 clk to done
        run(3, 1, 0, 0, 1050, 1'b0);  // continuous past 100 ms, then stop
        run(0, 2, 1, 2, 0, 1'b0);     // silent tone, cadence unchanged
        run(2, 0, 1, 2, 0, 1'b0);     // on_ms=0 acts as 1 ms
        run(2, 1, 1, 2, 30, 1'b0);    // stop on the completing edge suppresses done
        run(2, 1, 1, 2, 0, 1'b0);     // warble case when enabled
        run(3, 2, 1, 2, 0, 1'b1);     // input noise and start while busy

        // start together with stop in IDLE must be ignored
        @(negedge clk);
        half_period = DIV_W'(3);
        on_ms       = MS_W'(1);
        count       = CNT_W'(1);
        start       = 1'b1;
        stop        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle got busy=%b expected 0", busy);
        end

        run_reset();

        for (int k = 0; k < 20; k++) begin
            hp    = $urandom_range(0, 5);
            on    = $urandom_range(0, 3);
            off   = $urandom_range(0, 2);
            cnt   = $urandom_range(0, 4);
            noise = 1'($urandom_range(0, 1));
            lon   = ((on == 0) ? 1 : on) * MS;
            if (cnt == 0) begin
                s = $urandom_range(1, 300);
            end else begin
                end_edge = cnt * lon + (cnt - 1) * off * MS;
                s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, end_edge) : 0;
            end
            run(hp, on, off, cnt, s, noise);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
